// File: rtl/nios2e_seg_scroll_ctrl_if.sv
// Avalon-MM slave bus bundle for the 7-segment scroll controller.
interface nios2e_seg_scroll_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2e_seg_scroll_ctrl.sv
// 4-digit 7-segment driver: direct raw-segment mode or prescaled scrolling of
// hex characters queued by the CPU through a small character FIFO.
module nios2e_seg_scroll_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int PER_W      = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios2e_seg_scroll_ctrl_if.slave avs,
  output logic [27:0]            out_port
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [27:0]   ALL_OFF_C = ACTIVE_LOW ? 28'hFFFFFFF : 28'h0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [4:0] ch);
    logic [6:0] seg;
    if (ch[4]) begin
      seg = 7'h00;
    end else begin
      case (ch[3:0])
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        4'hF: seg = 7'h71;
        default: seg = 7'h00;
      endcase
    end
    return seg;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [3:0]        ctrl_r;
  logic [27:0]       direct_r;
  logic [PER_W-1:0]  period_r, cnt_r;
  logic [4:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r, pending_r;
  logic [3:0][6:0]   dig_r;
  logic [27:0]       out_r;

  logic wr_s, clear_s, ctrl_wr_s, dir_wr_s, per_wr_s, push_req_s, stat_wr_s;
  logic active_s, counting_s, tick_s, step_s, pend_set_s;
  logic pop_s, repush_s, pop_nl_s, push_ok_s, ovf_set_s, fifo_we_s;
  logic full_s, empty_s;
  logic [4:0]  head_s, fifo_wd_s;
  logic [27:0] raw_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign wr_s       = avs.chipselect & ~avs.write_n;
  assign ctrl_wr_s  = wr_s & (avs.address == 3'd0);
  assign dir_wr_s   = wr_s & (avs.address == 3'd1);
  assign per_wr_s   = wr_s & (avs.address == 3'd2);
  assign push_req_s = wr_s & (avs.address == 3'd3);
  assign stat_wr_s  = wr_s & (avs.address == 3'd4);
  assign clear_s    = ctrl_wr_s & avs.writedata[4];
  assign unused_s   = &{1'b0, avs.writedata[31:28]};

  assign active_s   = ctrl_r[0] & ctrl_r[1];
  assign counting_s = active_s & ~clear_s & ((state_r == ST_RUN) | (state_r == ST_STEP));
  // A PERIOD write suppresses the tick of that cycle.
  assign tick_s     = counting_s & ~per_wr_s & (cnt_r == {PER_W{1'b0}});

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign head_s    = fifo_mem[rd_ptr_r];
  assign pop_s     = step_s & ~empty_s;
  assign repush_s  = pop_s & ctrl_r[3];
  assign pop_nl_s  = pop_s & ~ctrl_r[3];
  assign push_ok_s = push_req_s & (~full_s | pop_nl_s);
  assign ovf_set_s = push_req_s & ~push_ok_s;
  assign fifo_we_s = push_ok_s | repush_s;
  assign fifo_wd_s = repush_s ? head_s : avs.writedata[4:0];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (clear_s) begin
      state_nxt_s = active_s ? ST_RUN : ST_IDLE;
    end else if (!active_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_RUN;
        ST_RUN:  state_nxt_s = tick_s ? ST_STEP : ST_RUN;
        ST_STEP: begin
          if (push_req_s) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = tick_s ? ST_STEP : ST_RUN;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: a CPU push on the step cycle defers the step
  always_comb begin
    step_s     = 1'b0;
    pend_set_s = 1'b0;
    if (!clear_s && active_s && (state_r == ST_STEP)) begin
      if (push_req_s) begin
        pend_set_s = 1'b1;
      end else begin
        step_s = 1'b1;
      end
    end else begin
      step_s     = 1'b0;
      pend_set_s = 1'b0;
    end
  end

  // Prescaler: held at PERIOD outside RUN/STEP, reloads on zero or PERIOD write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {PER_W{1'b0}};
    end else if (clear_s || !active_s || (state_r == ST_IDLE)) begin
      cnt_r <= period_r;
    end else if (per_wr_s) begin
      cnt_r <= avs.writedata[PER_W-1:0];
    end else if (cnt_r == {PER_W{1'b0}}) begin
      cnt_r <= period_r;
    end else begin
      cnt_r <= cnt_r - PER_W'(1);
    end
  end

  // CPU-visible configuration and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r    <= 4'h0;
      direct_r  <= 28'h0;
      period_r  <= {PER_W{1'b0}};
      ovf_r     <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      if (ctrl_wr_s) ctrl_r <= avs.writedata[3:0];
      if (dir_wr_s)  direct_r <= avs.writedata[27:0];
      if (per_wr_s)  period_r <= avs.writedata[PER_W-1:0];
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (stat_wr_s && avs.writedata[7]) begin
        ovf_r <= 1'b0;
      end
      pending_r <= pend_set_s;
    end
  end

  // FIFO pointers, occupancy and scroll digits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      dig_r    <= 28'h0;
    end else if (clear_s) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      dig_r    <= 28'h0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        dig_r    <= {dig_r[2:0], seg_decode(head_s)};
      end
      if (fifo_we_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (push_ok_s && !pop_nl_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_nl_s && !push_ok_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Character storage, no reset needed: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (fifo_we_s) fifo_mem[wr_ptr_r] <= fifo_wd_s;
  end

  // Display source select
  always_comb begin
    raw_s = 28'h0;
    if (ctrl_r[2]) begin
      raw_s = 28'h0;
    end else if (!ctrl_r[1]) begin
      raw_s = direct_r;
    end else begin
      raw_s = dig_r;
    end
  end

  // Registered segment output, polarity applied last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r <= ALL_OFF_C;
    end else begin
      out_r <= ACTIVE_LOW ? ~raw_s : raw_s;
    end
  end

  assign out_port = out_r;

  // Status word assembly
  always_comb begin
    status_s            = 32'h0;
    status_s[CW-1:0]    = count_r;
    status_s[5]         = empty_s;
    status_s[6]         = full_s;
    status_s[7]         = ovf_r;
    status_s[8]         = pending_r;
  end

  // Zero-wait-state read mux
  always_comb begin
    avs.readdata = 32'h0;
    case (avs.address)
      3'd0:    avs.readdata = {28'h0, ctrl_r};
      3'd1:    avs.readdata = {4'h0, direct_r};
      3'd2:    avs.readdata = 32'(period_r);
      3'd4:    avs.readdata = status_s;
      default: avs.readdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_nios2e_seg_scroll_ctrl.sv
// Bench for nios2e_seg_scroll_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_nios2e_seg_scroll_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [27:0] out_port;

  nios2e_seg_scroll_ctrl_if bus ();

  nios2e_seg_scroll_ctrl #(
    .FIFO_DEPTH(16),
    .ACTIVE_LOW(1'b1),
    .PER_W(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs(bus.slave),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]  m_ctrl;
  logic [27:0] m_direct;
  logic [23:0] m_period;
  int          m_cnt;
  logic [4:0]  m_q [$];
  bit          m_ovf, m_pend, m_run, m_due;
  logic [6:0]  m_dig [4];
  logic [27:0] m_out;

  bit          mw, mclr, mpush, mact, mtick;
  logic [2:0]  ma;
  logic [31:0] md;
  logic [4:0]  mh;
  logic [27:0] mraw;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'h0, m_ctrl};
      3'd1:    return {4'h0, m_direct};
      3'd2:    return {8'h0, m_period};
      3'd4:    return {23'h0, m_pend, m_ovf, (m_q.size() == 16), (m_q.size() == 0), 5'(m_q.size())};
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_ctrl = 4'h0; m_direct = 28'h0; m_period = 24'h0; m_cnt = 0;
      m_q.delete(); m_ovf = 1'b0; m_pend = 1'b0; m_run = 1'b0; m_due = 1'b0;
      m_dig = '{default: 7'h00};
      m_out = 28'hFFFFFFF;
    end else begin
      mw    = bus.chipselect && !bus.write_n;
      ma    = bus.address;
      md    = bus.writedata;
      mclr  = mw && (ma == 3'd0) && md[4];
      mpush = mw && (ma == 3'd3);
      mact  = m_ctrl[0] && m_ctrl[1];
      if (m_ctrl[2]) mraw = 28'h0;
      else if (!m_ctrl[1]) mraw = m_direct;
      else mraw = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      m_out = ~mraw;
      if (mclr) begin
        m_q.delete(); m_dig = '{default: 7'h00};
        m_pend = 1'b0; m_due = 1'b0; m_cnt = m_period; m_run = mact;
      end else if (!mact) begin
        m_run = 1'b0; m_due = 1'b0; m_pend = 1'b0; m_cnt = m_period;
      end else if (!m_run) begin
        m_run = 1'b1; m_cnt = m_period;
      end else begin
        mtick = 1'b0;
        m_pend = 1'b0;
        if (mw && ma == 3'd2) m_cnt = md[23:0];
        else if (m_cnt == 0) begin mtick = 1'b1; m_cnt = m_period; end
        else m_cnt--;
        if (m_due && mpush) begin
          m_pend = 1'b1;
        end else if (m_due) begin
          if (m_q.size() > 0) begin
            mh = m_q.pop_front();
            m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0];
            m_dig[0] = mh[4] ? 7'h00 : HEX[mh[3:0]];
            if (m_ctrl[3]) m_q.push_back(mh);
          end
          m_due = mtick;
        end else begin
          m_due = mtick;
        end
      end
      if (mpush) begin
        if (m_q.size() < 16) m_q.push_back(md[4:0]);
        else m_ovf = 1'b1;
      end
      if (mw && ma == 3'd4 && md[7]) m_ovf = 1'b0;
      if (mw && ma == 3'd0) m_ctrl = md[3:0];
      if (mw && ma == 3'd1) m_direct = md[27:0];
      if (mw && ma == 3'd2) m_period = md[23:0];
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("out_port", {4'h0, out_port}, {4'h0, m_out});
    check("readdata", bus.readdata, m_read(bus.address));
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #2;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd4; bus.writedata = 32'h0;
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd4; bus.writedata = 32'h0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("reset_out", {4'h0, out_port}, 32'h0FFFFFFF);
    check("reset_status", bus.readdata, 32'h20);

    // Direct mode
    wr(3'd1, 32'h6);
    wr(3'd0, 32'h1);
    @(negedge clk);
    check("direct_out", {4'h0, out_port}, 32'h0FFFFFF9);
    wr(3'd0, 32'h5);
    @(posedge clk); @(negedge clk);
    check("blank_out", {4'h0, out_port}, 32'h0FFFFFFF);

    // Scroll four characters
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h3);
    for (int i = 1; i <= 4; i++) wr(3'd3, 32'(i));
    wr(3'd0, 32'h3);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("scroll_out", {4'h0, out_port}, 32'h0F291819);
    check("scroll_status", bus.readdata, 32'h20);

    // Loop mode: stop after the fifth step
    wr(3'd0, 32'h10);
    for (int i = 1; i <= 4; i++) wr(3'd3, 32'(i));
    wr(3'd0, 32'hB);
    repeat (22) @(posedge clk);
    #2;
    wr(3'd0, 32'hA);
    @(negedge clk);
    check("loop_digit0", {25'h0, out_port[6:0]}, 32'h79);
    check("loop_status", bus.readdata, 32'h4);

    // Push collides with the step cycle
    wr(3'd0, 32'h10);
    wr(3'd3, 32'h1);
    wr(3'd3, 32'h2);
    wr(3'd0, 32'hB);
    repeat (5) @(posedge clk);
    #2;
    wr(3'd3, 32'h5);
    @(negedge clk);
    check("collide_pending", bus.readdata, 32'h103);
    @(negedge clk);
    check("collide_after", bus.readdata, 32'h3);

    // Overflow with the engine disabled
    wr(3'd0, 32'h10);
    for (int i = 0; i < 17; i++) wr(3'd3, 32'(i & 15));
    @(negedge clk);
    check("ovf_status", bus.readdata, 32'hD0);
    wr(3'd4, 32'h80);
    @(negedge clk);
    check("ovf_cleared", bus.readdata, 32'h50);

    // Period rewrites while running
    wr(3'd0, 32'h3);
    repeat (10) @(posedge clk);
    #2;
    wr(3'd2, 32'h5);
    repeat (20) @(posedge clk);
    #2;
    wr(3'd2, 32'h0);
    repeat (6) @(posedge clk);
    #2;

    // Reset mid-scroll
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("midreset_out", {4'h0, out_port}, 32'h0FFFFFFF);
    check("midreset_status", bus.readdata, 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
